// File: rtl/tlb_pkg.sv
// Shared TLB definitions: walk-controller states and index-width helper.
package tlb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PTW_REQ,
      S_PTW_WAIT
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tlb_onehot_mux.sv
// AND-OR selector over a hit vector with multiple-hit detection.
module tlb_onehot_mux #(
   parameter int N = 8,
   parameter int W = 20
) (
   input  logic [N-1:0]        sel_i,
   input  logic [N-1:0][W-1:0] data_i,
   output logic [W-1:0]        data_o,
   output logic                multihit_o
);

   always_comb begin
      data_o = '0;
      for (int i = 0; i < N; i++) begin
         data_o = data_o | (data_i[i] & {W{sel_i[i]}});
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multihit_o = |(sel_i & (sel_i - N'(1)));

endmodule

// File: rtl/tlb_ppn_array.sv
// L1 TLB PPN store: qualifies CAM hits, selects the PPN, and owns
// the page-table-walk miss path with round-robin refill.
module tlb_ppn_array
   import tlb_pkg::*;
#(
   parameter  int ENTRIES = 8,
   parameter  int PPN_W   = 20,
   localparam int IDX_W   = idx_w(ENTRIES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ENTRIES-1:0] req_hits,
   input  logic               req_passthrough,
   input  logic [PPN_W-1:0]   req_passthrough_ppn,
   output logic               resp_valid,
   output logic [PPN_W-1:0]   resp_ppn,
   output logic               resp_multihit,
   output logic               resp_fault,
   output logic               ptw_req_valid,
   input  logic               ptw_req_ready,
   input  logic               ptw_resp_valid,
   input  logic [PPN_W-1:0]   ptw_resp_ppn,
   input  logic               ptw_resp_error,
   output logic               refill_we,
   output logic [IDX_W-1:0]   refill_idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

   state_e                    state_q, state_d;
   logic [ENTRIES-1:0]        valid_q, valid_d;
   logic [IDX_W-1:0]          victim_q, victim_d;
   logic                      flushed_q, flushed_d;
   logic [ENTRIES-1:0][PPN_W-1:0] ppn_q;

   logic                      rvalid_q, rvalid_d;
   logic [PPN_W-1:0]          rppn_q, rppn_d;
   logic                      rmulti_q, rmulti_d;
   logic                      rfault_q, rfault_d;
   logic                      rwe_q, rwe_d;
   logic [IDX_W-1:0]          ridx_q, ridx_d;

   logic [ENTRIES-1:0]        q;
   logic [PPN_W-1:0]          sel_ppn;
   logic                      sel_multi;
   logic                      wr_en;

   assign q = req_hits & valid_q & {ENTRIES{~flush}};

   tlb_onehot_mux #(
      .N (ENTRIES),
      .W (PPN_W)
   ) u_mux (
      .sel_i      (q),
      .data_i     (ppn_q),
      .data_o     (sel_ppn),
      .multihit_o (sel_multi)
   );

   // A flush seen at any point of the walk suppresses its refill.
   assign wr_en = (state_q == S_PTW_WAIT) && ptw_resp_valid &&
                  !ptw_resp_error && !flush && !flushed_q;

   always_comb begin
      state_d  = state_q;
      rvalid_d = 1'b0;
      rppn_d   = '0;
      rmulti_d = 1'b0;
      rfault_d = 1'b0;
      rwe_d    = 1'b0;
      ridx_d   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_passthrough || (|q)) begin
                  rvalid_d = 1'b1;
                  rppn_d   = req_passthrough ? req_passthrough_ppn : sel_ppn;
                  rmulti_d = !req_passthrough && sel_multi;
               end else begin
                  state_d = S_PTW_REQ;
               end
            end
         end
         S_PTW_REQ: begin
            if (ptw_req_ready) state_d = S_PTW_WAIT;
         end
         S_PTW_WAIT: begin
            if (ptw_resp_valid) begin
               state_d  = S_IDLE;
               rvalid_d = 1'b1;
               rfault_d = ptw_resp_error;
               rppn_d   = ptw_resp_error ? '0 : ptw_resp_ppn;
               rwe_d    = wr_en;
               ridx_d   = wr_en ? victim_q : '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      flushed_d = flushed_q;
      if (state_q != S_IDLE && flush) flushed_d = 1'b1;
      if (state_d == S_IDLE) flushed_d = 1'b0;

      valid_d = valid_q;
      if (wr_en) valid_d[victim_q] = 1'b1;
      if (flush) valid_d = '0;

      victim_d = victim_q;
      if (wr_en) victim_d = (victim_q == LAST) ? '0 : victim_q + IDX_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         valid_q   <= '0;
         victim_q  <= '0;
         flushed_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rppn_q    <= '0;
         rmulti_q  <= 1'b0;
         rfault_q  <= 1'b0;
         rwe_q     <= 1'b0;
         ridx_q    <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         victim_q  <= victim_d;
         flushed_q <= flushed_d;
         rvalid_q  <= rvalid_d;
         rppn_q    <= rppn_d;
         rmulti_q  <= rmulti_d;
         rfault_q  <= rfault_d;
         rwe_q     <= rwe_d;
         ridx_q    <= ridx_d;
      end
   end

   // PPN storage carries no reset; valid bits gate its use.
   always_ff @(posedge clk) begin
      if (wr_en) ppn_q[victim_q] <= ptw_resp_ppn;
   end

   assign req_ready     = (state_q == S_IDLE);
   assign ptw_req_valid = (state_q == S_PTW_REQ);
   assign resp_valid    = rvalid_q;
   assign resp_ppn      = rppn_q;
   assign resp_multihit = rmulti_q;
   assign resp_fault    = rfault_q;
   assign refill_we     = rwe_q;
   assign refill_idx    = ridx_q;

endmodule

// File: tb/tb_tlb_ppn_array.sv
// Self-checking bench for tlb_ppn_array against an entry-array model.
module tb_tlb_ppn_array;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_hits;
   logic        req_passthrough;
   logic [19:0] req_passthrough_ppn;
   logic        resp_valid;
   logic [19:0] resp_ppn;
   logic        resp_multihit;
   logic        resp_fault;
   logic        ptw_req_valid;
   logic        ptw_req_ready;
   logic        ptw_resp_valid;
   logic [19:0] ptw_resp_ppn;
   logic        ptw_resp_error;
   logic        refill_we;
   logic [2:0]  refill_idx;

   int errors = 0;
   int checks = 0;

   logic [19:0] m_ppn [8];
   bit          m_valid [8];
   int          m_victim;

   tlb_ppn_array #(.ENTRIES(8), .PPN_W(20)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .flush               (flush),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_hits            (req_hits),
      .req_passthrough     (req_passthrough),
      .req_passthrough_ppn (req_passthrough_ppn),
      .resp_valid          (resp_valid),
      .resp_ppn            (resp_ppn),
      .resp_multihit       (resp_multihit),
      .resp_fault          (resp_fault),
      .ptw_req_valid       (ptw_req_valid),
      .ptw_req_ready       (ptw_req_ready),
      .ptw_resp_valid      (ptw_resp_valid),
      .ptw_resp_ppn        (ptw_resp_ppn),
      .ptw_resp_error      (ptw_resp_error),
      .refill_we           (refill_we),
      .refill_idx          (refill_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
   endtask

   // One lookup; on a miss, drive the walker with the given delays.
   // fmode: 1 = flush during walk wait, 2 = flush with walk result.
   task automatic access(input logic [7:0] hits, input bit pt,
                         input logic [19:0] ptppn, input bit fl_now,
                         input logic [19:0] wppn, input bit werr,
                         input int rdelay, input int wdelay,
                         input int fmode);
      logic [19:0] exp_ppn;
      int          cnt;
      bit          flushed;
      bit          wr;
      int          wd;
      @(negedge clk);
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_resp_ppn", resp_ppn, 0);
      chk("req_ready", req_ready, 1);
      req_valid = 1; req_hits = hits; req_passthrough = pt;
      req_passthrough_ppn = ptppn; flush = fl_now;
      exp_ppn = '0; cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (hits[i] && m_valid[i] && !fl_now) begin
            exp_ppn = exp_ppn | m_ppn[i];
            cnt++;
         end
      end
      if (fl_now) model_clear();
      @(negedge clk);
      req_valid = 0; req_hits = '0; req_passthrough = 0; flush = 0;
      if (pt || cnt > 0) begin
         chk("hit_valid", resp_valid, 1);
         chk("hit_ppn", resp_ppn, pt ? ptppn : exp_ppn);
         chk("hit_multi", resp_multihit, (!pt && cnt > 1) ? 1 : 0);
         chk("hit_fault", resp_fault, 0);
         chk("hit_we", refill_we, 0);
         return;
      end
      chk("miss_resp_valid", resp_valid, 0);
      chk("miss_ptw_req", ptw_req_valid, 1);
      for (int k = 0; k < rdelay; k++) begin
         @(negedge clk);
         chk("ptw_req_held", ptw_req_valid, 1);
         chk("ready_low_req", req_ready, 0);
      end
      ptw_req_ready = 1;
      @(negedge clk);
      ptw_req_ready = 0;
      chk("ptw_req_drop", ptw_req_valid, 0);
      chk("ready_low_wait", req_ready, 0);
      flushed = 0;
      wd = (fmode == 1 && wdelay < 1) ? 1 : wdelay;
      for (int k = 0; k < wd; k++) begin
         if (fmode == 1 && k == 0) flush = 1;
         @(negedge clk);
         flush = 0;
         if (fmode == 1 && k == 0) begin
            model_clear();
            flushed = 1;
         end
         chk("wait_ready", req_ready, 0);
         chk("wait_resp", resp_valid, 0);
      end
      ptw_resp_valid = 1; ptw_resp_ppn = wppn; ptw_resp_error = werr;
      flush = (fmode == 2);
      @(negedge clk);
      ptw_resp_valid = 0; ptw_resp_ppn = '0; ptw_resp_error = 0;
      flush = 0;
      if (fmode == 2) model_clear();
      wr = !werr && fmode != 2 && !flushed;
      chk("walk_valid", resp_valid, 1);
      chk("walk_ppn", resp_ppn, werr ? 20'h0 : wppn);
      chk("walk_fault", resp_fault, werr);
      chk("walk_multi", resp_multihit, 0);
      chk("walk_we", refill_we, wr);
      chk("walk_idx", refill_idx, wr ? m_victim : 0);
      chk("walk_ready", req_ready, 1);
      if (wr) begin
         m_ppn[m_victim] = wppn;
         m_valid[m_victim] = 1;
         m_victim = (m_victim + 1) % 8;
      end
   endtask

   initial begin
      reset_n = 0; flush = 0; req_valid = 0; req_hits = '0;
      req_passthrough = 0; req_passthrough_ppn = '0;
      ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_ppn = '0;
      ptw_resp_error = 0;
      model_clear();
      m_victim = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_ptw_req", ptw_req_valid, 0);
      chk("rst_we", refill_we, 0);
      chk("rst_idx", refill_idx, 0);
      reset_n = 1;

      for (int i = 0; i < 8; i++)
         access(8'h00, 0, 0, 0, 20'h01000 + 20'(i), 0, 0, 1, 0);
      access(8'h20, 0, 0, 0, 0, 0, 0, 0, 0);
      access(8'hFF, 1, 20'hABCDE, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      req_valid = 1; req_hits = 8'h01;
      @(negedge clk);
      req_hits = 8'h80;
      chk("b2b_first", resp_ppn, 20'h01000);
      chk("b2b_first_v", resp_valid, 1);
      @(negedge clk);
      req_valid = 0; req_hits = '0;
      chk("b2b_second", resp_ppn, 20'h01007);
      chk("b2b_second_v", resp_valid, 1);

      access(8'h00, 0, 0, 0, 20'h000F0, 0, 3, 0, 0);
      access(8'h00, 0, 0, 0, 20'h00F00, 0, 0, 0, 0);
      access(8'h03, 0, 0, 0, 0, 0, 0, 0, 0);
      access(8'h00, 0, 0, 0, 20'h55555, 1, 1, 2, 0);
      access(8'h00, 0, 0, 0, 20'h22222, 0, 0, 0, 0);
      access(8'h00, 0, 0, 0, 20'h12345, 0, 0, 1, 1);
      access(8'hFF, 0, 0, 0, 20'h33333, 0, 0, 0, 0);
      access(8'h00, 0, 0, 0, 20'h44444, 0, 0, 0, 2);
      access(8'hFF, 0, 0, 1, 20'h66666, 0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         access(8'($urandom), ($urandom % 8) == 0, 20'($urandom),
                ($urandom % 16) == 0, 20'($urandom),
                ($urandom % 8) == 0, $urandom % 3, $urandom % 3,
                $urandom % 5);
      end

      @(negedge clk);
      req_valid = 1; req_hits = '0;
      @(negedge clk);
      req_valid = 0;
      chk("midwalk_req", ptw_req_valid, 1);
      reset_n = 0;
      #1;
      chk("midwalk_rst_ready", req_ready, 1);
      chk("midwalk_rst_ptw", ptw_req_valid, 0);
      model_clear();
      m_victim = 0;
      @(negedge clk);
      reset_n = 1;
      ptw_resp_valid = 1; ptw_resp_ppn = 20'h77777;
      @(negedge clk);
      ptw_resp_valid = 0; ptw_resp_ppn = '0;
      chk("late_resp_ignored", resp_valid, 0);
      chk("late_we_ignored", refill_we, 0);
      access(8'hFF, 0, 0, 0, 20'h88888, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tlb_ppn_array.md
# tlb_ppn_array

Parametrised L1 TLB physical-page-number store and resolver. Holds `ENTRIES` PPNs with per-entry valid bits, qualifies the external tag-match hit vector, and AND-OR selects the translated PPN into a registered response. It owns the miss path: it issues a page-table-walk request, writes the returned PPN into a round-robin victim entry, and replays the response. It sits between the TLB tag CAM (which supplies `req_hits` and mirrors refills via `refill_*`) and the L1 cache tag-compare stage.

## Interface
- `ENTRIES`, 8, number of TLB entries (≥2).
- `PPN_W`, 20, PPN width.
- `IDX_W`, `$clog2(ENTRIES)`, entry index width (derived, not overridden).

- `clk`  in  1  clock.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `flush`  in  1  invalidate all entries.
- `req_valid`  in  1  lookup request.
- `req_ready`  out  1  block can accept a request.
- `req_hits`  in  ENTRIES  raw tag-match vector from the CAM.
- `req_passthrough`  in  1  translation disabled; use `req_passthrough_ppn`.
- `req_passthrough_ppn`  in  PPN_W  untranslated PPN.
- `resp_valid`  out  1  single-cycle response pulse.
- `resp_ppn`  out  PPN_W  resolved PPN.
- `resp_multihit`  out  1  more than one qualified hit; `resp_ppn` is the OR of the hit PPNs.
- `resp_fault`  out  1  walk returned an error.
- `ptw_req_valid`  out  1  walk request.
- `ptw_req_ready`  in  1  walker accepts the request.
- `ptw_resp_valid`  in  1  walk result valid.
- `ptw_resp_ppn`  in  PPN_W  walk result PPN.
- `ptw_resp_error`  in  1  walk fault.
- `refill_we`  out  1  entry written this cycle.
- `refill_idx`  out  IDX_W  entry being written.

## Operation
- Qualified hits: `q = req_hits & valid & {ENTRIES{~flush}}`. Flush wins over a same-cycle lookup, so that lookup is a miss.
- Selection: `ppn = OR_i(q[i] ? ppns[i] : 0)`. Passthrough overrides the hit vector entirely and never raises `resp_multihit`.
- FSM states:
  - IDLE: `req_ready=1`.
    - Accept with passthrough or `|q`: register the response; `resp_valid` fires next cycle; stay in IDLE.
    - Accept with `q==0` and no passthrough: go to PTW_REQ.
  - PTW_REQ: `ptw_req_valid=1`, `req_ready=0`. On `ptw_req_ready`, go to PTW_WAIT.
  - PTW_WAIT: `req_ready=0`. On `ptw_resp_valid`:
    - No error: write `ppns[victim]=ptw_resp_ppn`, set `valid[victim]`, pulse `refill_we` with `refill_idx=victim`, advance `victim` (wraps `ENTRIES-1`→0), respond with `resp_ppn=ptw_resp_ppn`.
    - Error: no write, no victim advance; respond with `resp_fault=1`, `resp_ppn=0`.
    - Either way, return to IDLE.
- Flush:
  - Clears all valid bits in one cycle; PPN contents are not cleared.
  - Does not abort an outstanding walk.
  - A walk result arriving in the same cycle as `flush`, or after a flush during that walk, is still returned on `resp_*` but not written (`refill_we=0`) and does not advance the victim.
- `resp_*` outputs are zero whenever `resp_valid=0`.

## Timing
- Reset values: state IDLE; `valid=0`, `victim=0`; all outputs 0 except `req_ready=1`. PPN storage is not reset.
- Hit or passthrough latency: accepted at edge t → `resp_valid` during cycle t+1. Back-to-back hits give one response per cycle.
- Miss:
  - `ptw_req_valid` from cycle t+1, held until `ptw_req_ready`.
  - `ptw_resp_valid` in cycle u → `resp_valid` and `refill_we` in cycle u+1.
  - `req_ready` returns in cycle u+1.
- There is no back-pressure on `resp`; the consumer must always sink it.
- Reset asserted mid-walk: immediate return to IDLE. Any late `ptw_resp_valid` seen in IDLE is ignored.

## Structure
- Shared package `tlb_pkg`: state enum (`S_IDLE`, `S_PTW_REQ`, `S_PTW_WAIT`) and the `IDX_W` helper function.
- Sub-module `tlb_onehot_mux` (params `N`, `W`): purely combinational AND-OR selector plus multihit detect (`|(q & (q-1))`). It is reused by the future L2 TLB.

## Test plan
- Reset, fill entries 0..7 via 8 misses (PPN `20'h1000+i`), then hit entry 5 → `resp_ppn=20'h01005` one cycle after accept; `refill_idx` sequence 0..7.
- Passthrough with `req_hits=8'hFF`, `req_passthrough_ppn=20'hABCDE` → `resp_ppn=20'hABCDE`, `resp_multihit=0`.
- Hits 0x03 with PPNs `20'h00F0`/`20'h0F00` → `resp_ppn=20'h0FF0`, `resp_multihit=1`.
- Ninth miss after a full fill → victim wraps to 0 (`refill_idx=0`); `ptw_req_ready` held low 3 cycles → `ptw_req_valid` stays high, `req_ready=0` throughout.
- Walk error → `resp_fault=1`, `resp_ppn=0`, no `refill_we`; the next miss still uses the same victim.
- `flush` during PTW_WAIT, then result `20'h12345` → response `20'h12345` with `refill_we=0`; a subsequent lookup with `req_hits=8'hFF` misses.
